// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, deserialise, and present the last two bytes as ASCII hex.
// Optional macro PS2_E0_DROP_EN: discard the 0xE0 extended-key prefix instead of shifting it into keyCode.
module ps2_keycode_rx #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 65_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [31:0] keyCode,
   output logic        key_valid,
   output logic        rx_error
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d, filt_prev_q;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic [1:0]    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [31:0]   key_q, key_d;
   logic          kv_q, kv_d, err_q, err_d;
   logic          fall_c, timeout_c;

   function automatic logic [7:0] hex_c(input logic [3:0] n);
      return (n <= 4'd9) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
   endfunction

   // Filtered clock flips only after the synced level disagrees for FILTER_LEN cycles in a row.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = ~filt_q;
         else filt_cnt_d = filt_cnt_q + FW'(1);
      end
   end

   assign fall_c    = filt_prev_q & ~filt_q;
   assign timeout_c = (state_q != ST_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   // Frame FSM, timeout and keyCode history; an edge takes priority over a simultaneous timeout.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      key_d     = key_q;
      kv_d      = 1'b0;
      err_d     = 1'b0;
      to_cnt_d  = (state_q == ST_IDLE || fall_c) ? '0 : to_cnt_q + TW'(1);
      if (fall_c) begin
         case (state_q)
            ST_IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = dat_s2_q;
               state_d = ST_STOP;
            end
            default: begin
               state_d = ST_IDLE;
               if (dat_s2_q && (^{shift_q, par_q})) begin
`ifdef PS2_E0_DROP_EN
                  if (shift_q != 8'hE0) begin
                     key_d = {key_q[15:0], hex_c(shift_q[7:4]), hex_c(shift_q[3:0])};
                     kv_d  = 1'b1;
                  end
`else
                  key_d = {key_q[15:0], hex_c(shift_q[7:4]), hex_c(shift_q[3:0])};
                  kv_d  = 1'b1;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         endcase
      end else if (timeout_c) begin
         state_d  = ST_IDLE;
         err_d    = 1'b1;
         to_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         filt_cnt_q  <= '0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
         key_q       <= 32'h0;
         kv_q        <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         clk_s1_q    <= ps2_clk;
         clk_s2_q    <= clk_s1_q;
         dat_s1_q    <= ps2_data;
         dat_s2_q    <= dat_s1_q;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         filt_cnt_q  <= filt_cnt_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         to_cnt_q    <= to_cnt_d;
         key_q       <= key_d;
         kv_q        <= kv_d;
         err_q       <= err_d;
      end
   end

   assign keyCode   = key_q;
   assign key_valid = kv_q;
   assign rx_error  = err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: vector table of frames plus hand-written timeout/glitch/reset sequences.
module tb_ps2_keycode_rx;

   localparam int unsigned HALF = 40;
   localparam int unsigned TO   = 2000;

   logic        clk = 1'b0;
   logic        rst, ps2_clk, ps2_data;
   logic [31:0] keyCode;
   logic        key_valid, rx_error;

   int checks = 0, errors = 0, kv_cnt = 0, err_cnt = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [7:0]  data;
      bit          bad_par;
      logic [31:0] exp_key;
   } vec_t;

   vec_t vecs[5];

   ps2_keycode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keyCode(keyCode), .key_valid(key_valid), .rx_error(rx_error)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives the first nbits of a frame; optional 3-cycle low glitch inside the high phase of bit 3.
   task automatic send_bits(input logic [7:0] d, input bit bad, input int nbits, input bit glitch);
      logic [10:0] fr;
      fr = {1'b1, (~^d) ^ bad, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         if (glitch && i == 3) begin
            wait_cyc(15);
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(HALF - 18);
         end else begin
            wait_cyc(HALF);
         end
         ps2_clk = 1'b0;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad, input bit glitch);
      send_bits(d, bad, 11, glitch);
      wait_cyc(60);
   endtask

   // Scoreboard: each key_valid pops the next expected keyCode.
   always @(negedge clk) begin
      if (!rst) begin
         if (key_valid || rx_error) begin
            checks++;
            if (key_valid && rx_error) begin
               errors++;
               $display("FAIL exclusive key_valid=1 rx_error=1 required one-hot");
            end
         end
         if (key_valid) begin
            kv_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_key_valid keyCode=%h required no pulse", keyCode);
            end else begin
               check32("scoreboard_keyCode", keyCode, exp_q.pop_front());
            end
         end
         if (rx_error) err_cnt++;
      end
   end

   initial begin
      int kv0, e0;
      vecs[0] = '{8'h1C, 1'b0, 32'h0000_3143};
      vecs[1] = '{8'hF0, 1'b0, 32'h3143_4630};
      vecs[2] = '{8'h1C, 1'b0, 32'h4630_3143};
      vecs[3] = '{8'h29, 1'b1, 32'h4630_3143};
      vecs[4] = '{8'h23, 1'b0, 32'h3143_3233};

      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(1);
      check32("reset_keyCode", keyCode, 32'h0);
      check32("reset_key_valid", 32'(key_valid), 32'h0);
      check32("reset_rx_error", 32'(rx_error), 32'h0);

      wait_cyc(10_000);
      check32("idle_key_valid_count", 32'(kv_cnt), 32'h0);
      check32("idle_rx_error_count", 32'(err_cnt), 32'h0);
      check32("idle_keyCode", keyCode, 32'h0);

      for (int i = 0; i < 5; i++) begin
         kv0 = kv_cnt; e0 = err_cnt;
         if (!vecs[i].bad_par) exp_q.push_back(vecs[i].exp_key);
         send_frame(vecs[i].data, vecs[i].bad_par, 1'b0);
         check32($sformatf("vec%0d_keyCode", i), keyCode, vecs[i].exp_key);
         check32($sformatf("vec%0d_kv_pulses", i), 32'(kv_cnt - kv0), 32'(!vecs[i].bad_par));
         check32($sformatf("vec%0d_err_pulses", i), 32'(err_cnt - e0), 32'(vecs[i].bad_par));
         check32($sformatf("vec%0d_pending", i), 32'(exp_q.size()), 32'h0);
      end

      // Partial frame then silence: error only once the timeout expires.
      e0 = err_cnt; kv0 = kv_cnt;
      send_bits(8'h23, 1'b0, 5, 1'b0);
      wait_cyc(TO / 2);
      check32("timeout_early", 32'(err_cnt - e0), 32'h0);
      wait_cyc(TO);
      check32("timeout_err", 32'(err_cnt - e0), 32'h1);
      check32("timeout_keyCode", keyCode, 32'h3143_3233);
      exp_q.push_back(32'h3233_3233);
      send_frame(8'h23, 1'b0, 1'b0);
      check32("after_timeout_keyCode", keyCode, 32'h3233_3233);
      check32("after_timeout_kv", 32'(kv_cnt - kv0), 32'h1);

      // Short low glitches, idle and mid-frame.
      e0 = err_cnt; kv0 = kv_cnt;
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(50);
      exp_q.push_back(32'h3233_3233);
      send_frame(8'h23, 1'b0, 1'b1);
      check32("glitch_kv", 32'(kv_cnt - kv0), 32'h1);
      check32("glitch_err", 32'(err_cnt - e0), 32'h0);
      check32("glitch_keyCode", keyCode, 32'h3233_3233);

      // Reset in the middle of a frame.
      send_bits(8'h1C, 1'b0, 4, 1'b0);
      rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      wait_cyc(1);
      check32("midreset_keyCode", keyCode, 32'h0);
      e0 = err_cnt; kv0 = kv_cnt;
      exp_q.push_back(32'h0000_3239);
      send_frame(8'h29, 1'b0, 1'b0);
      check32("midreset_29_keyCode", keyCode, 32'h0000_3239);
      check32("midreset_err", 32'(err_cnt - e0), 32'h0);

      kv0 = kv_cnt;
`ifdef PS2_E0_DROP_EN
      exp_q.push_back(32'h3239_3143);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check32("e0_drop_low", {16'h0, keyCode[15:0]}, 32'h0000_3143);
      check32("e0_drop_kv", 32'(kv_cnt - kv0), 32'h1);
`else
      exp_q.push_back(32'h3239_4530);
      send_frame(8'hE0, 1'b0, 1'b0);
      check32("e0_keyCode", keyCode, 32'h3239_4530);
      check32("e0_kv", 32'(kv_cnt - kv0), 32'h1);
`endif

      wait_cyc(20);
      check32("final_pending", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
